// File: rtl/byte_decode_stream_if.sv
// ---------------------------------------------------------------------------
// byte_decode_stream_if
//   Groups the byte-input and coefficient-output handshakes of the
//   ByteDecode engine so they travel together as one port.
//
//   in_valid / in_ready / in_byte     : byte stream into the decoder
//   out_valid / out_ready / out_coeff : decoded coefficient stream out
//   out_last                          : marks the final coefficient of a frame
//
//   master : the environment side (byte source and coefficient sink)
//   slave  : the decoder itself
// ---------------------------------------------------------------------------
interface byte_decode_stream_if #(
    parameter int COEFF_W = 12
);
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         in_byte;
    logic               out_valid;
    logic               out_ready;
    logic [COEFF_W-1:0] out_coeff;
    logic               out_last;

    modport master (
        output in_valid, in_byte, out_ready,
        input  in_ready, out_valid, out_coeff, out_last
    );

    modport slave (
        input  in_valid, in_byte, out_ready,
        output in_ready, out_valid, out_coeff, out_last
    );
endinterface

// File: rtl/byte_decode_stream.sv
// ---------------------------------------------------------------------------
// byte_decode_stream
//   Streaming ByteDecode_d for Kyber. Accepts 32*d bytes per frame and emits
//   NUM_COEFFS coefficients of d bits each, LSB-first. When d == 12 the
//   coefficient is reduced mod Q with a single conditional subtraction.
//
//   clk, rst_n : rising-edge clock, synchronous active-low reset
//   start      : begin a frame (only honoured in IDLE)
//   d_sel      : coefficient width, latched when start is accepted
//   stream     : byte input / coefficient output handshakes (slave side)
//   busy       : frame in progress (RUN or DRAIN)
//   done       : one-cycle pulse after the last coefficient is taken
//   err        : one-cycle pulse when start arrives with an illegal d_sel
// ---------------------------------------------------------------------------
module byte_decode_stream #(
    parameter int MAX_D      = 12,
    parameter int NUM_COEFFS = 256,
    parameter int Q          = 3329,
    parameter int BUF_W      = MAX_D + 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [3:0]           d_sel,
    byte_decode_stream_if.slave  stream,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int CNT_W = $clog2(BUF_W + 1);
    localparam int CC_W  = $clog2(NUM_COEFFS + 1);
    localparam int BL_W  = $clog2((NUM_COEFFS / 8) * MAX_D + 1);

    localparam logic [CNT_W-1:0] FILL_LIMIT   = CNT_W'(BUF_W - 8);
    localparam logic [3:0]       MAX_D_SEL    = 4'(MAX_D);
    localparam logic [3:0]       REDUCE_D     = 4'd12;
    localparam logic [MAX_D-1:0] Q_VAL        = MAX_D'(Q);
    localparam logic [CC_W-1:0]  LAST_IDX     = CC_W'(NUM_COEFFS - 1);
    localparam logic [CC_W-1:0]  FRAME_COEFFS = CC_W'(NUM_COEFFS);
    localparam logic [BL_W-1:0]  BYTES_PER_D  = BL_W'(NUM_COEFFS / 8);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         d_q, d_d;
    logic [BL_W-1:0]    bytes_left_q, bytes_left_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CC_W-1:0]    coeff_cnt_q, coeff_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [MAX_D-1:0]   out_coeff_q, out_coeff_d;
    logic               out_last_q, out_last_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               in_ready;
    logic               accept;
    logic               pop;
    logic [MAX_D-1:0]   mask;
    logic [MAX_D-1:0]   raw;
    logic [MAX_D-1:0]   reduced;
    logic [BUF_W-1:0]   shifted;
    logic [CNT_W-1:0]   cnt_mid;

    // Handshake qualifiers and the extract/shift datapath. in_ready looks
    // only at registered state so the byte source never sees a comb path
    // back from its own in_valid. The mask wraps to all-ones for d == MAX_D,
    // which is exactly what a full-width extract needs.
    always_comb begin
        in_ready = (state_q == RUN) && (bytes_left_q != '0) && (bit_cnt_q <= FILL_LIMIT);
        accept   = in_ready && stream.in_valid;
        pop      = (state_q != IDLE) && (bit_cnt_q >= CNT_W'(d_q))
                   && (!out_valid_q || stream.out_ready) && (coeff_cnt_q < FRAME_COEFFS);
        mask     = (MAX_D'(1) << d_q) - MAX_D'(1);
        raw      = buf_q[MAX_D-1:0] & mask;
        reduced  = ((d_q == REDUCE_D) && (raw >= Q_VAL)) ? raw - Q_VAL : raw;
        shifted  = pop ? (buf_q >> d_q) : buf_q;
        cnt_mid  = pop ? (bit_cnt_q - CNT_W'(d_q)) : bit_cnt_q;
    end

    // Next-state logic. The datapath update runs first; the FSM case then
    // overrides it where a new frame is being set up. Bits above bit_cnt are
    // kept at zero, so an incoming byte can simply be OR-ed in above the
    // post-shift fill level.
    always_comb begin
        state_d      = state_q;
        d_d          = d_q;
        bytes_left_d = bytes_left_q;
        buf_d        = shifted;
        bit_cnt_d    = cnt_mid;
        coeff_cnt_d  = coeff_cnt_q;
        out_valid_d  = out_valid_q;
        out_coeff_d  = out_coeff_q;
        out_last_d   = out_last_q;
        done_d       = 1'b0;
        err_d        = 1'b0;

        if (out_valid_q && stream.out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (pop) begin
            out_valid_d = 1'b1;
            out_coeff_d = reduced;
            out_last_d  = (coeff_cnt_q == LAST_IDX);
            coeff_cnt_d = coeff_cnt_q + CC_W'(1);
        end

        if (accept) begin
            buf_d        = shifted | ({{(BUF_W-8){1'b0}}, stream.in_byte} << cnt_mid);
            bit_cnt_d    = cnt_mid + CNT_W'(8);
            bytes_left_d = bytes_left_q - BL_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((d_sel != 4'd0) && (d_sel <= MAX_D_SEL)) begin
                        state_d      = RUN;
                        d_d          = d_sel;
                        bytes_left_d = BL_W'(d_sel) * BYTES_PER_D;
                        buf_d        = '0;
                        bit_cnt_d    = '0;
                        coeff_cnt_d  = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept && (bytes_left_q == BL_W'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_valid_q && stream.out_ready && out_last_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; a reset mid-frame discards everything buffered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            d_q          <= '0;
            bytes_left_q <= '0;
            buf_q        <= '0;
            bit_cnt_q    <= '0;
            coeff_cnt_q  <= '0;
            out_valid_q  <= 1'b0;
            out_coeff_q  <= '0;
            out_last_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            d_q          <= d_d;
            bytes_left_q <= bytes_left_d;
            buf_q        <= buf_d;
            bit_cnt_q    <= bit_cnt_d;
            coeff_cnt_q  <= coeff_cnt_d;
            out_valid_q  <= out_valid_d;
            out_coeff_q  <= out_coeff_d;
            out_last_q   <= out_last_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign stream.in_ready  = in_ready;
    assign stream.out_valid = out_valid_q;
    assign stream.out_coeff = out_coeff_q;
    assign stream.out_last  = out_last_q;
    assign busy             = (state_q != IDLE);
    assign done             = done_q;
    assign err              = err_q;

endmodule

// File: tb/tb_byte_decode_stream.sv
// ---------------------------------------------------------------------------
// tb_byte_decode_stream
//   Randomised bench for byte_decode_stream. Frames are decoded by a
//   bit-level ByteDecode reference (coefficient i bit j = stream bit i*d+j)
//   and compared coefficient by coefficient.
// ---------------------------------------------------------------------------
module tb_byte_decode_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] d_sel;
    logic       busy;
    logic       done;
    logic       err;

    byte_decode_stream_if bus ();

    byte_decode_stream dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .d_sel  (d_sel),
        .stream (bus),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] tx_bytes [0:383];
    int         exp_coeff [0:255];
    int         rx_coeff [0:255];
    bit         rx_last [0:255];
    int         rx_count, bytes_acc, done_count, done_cyc, last_cyc;
    int         hold_errs, ready_errs;
    bit         timed_out, stall_ready_low;

    // Reference ByteDecode_d computed straight from the bit-order rule.
    function automatic void build_expected(input int d);
        for (int i = 0; i < 256; i++) begin
            int v = 0;
            for (int j = 0; j < d; j++) begin
                int b = i * d + j;
                v = v | (int'(tx_bytes[b / 8][b % 8]) << j);
            end
            if (d == 12 && v >= 3329) v = v - 3329;
            exp_coeff[i] = v;
        end
    endfunction

    task automatic start_frame(input int d);
        @(posedge clk); #1;
        start = 1'b1;
        d_sel = 4'(d);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Drives one frame with random valid/ready gaps and records what comes
    // out. in_ready is predicted from the buffered-bit count implied by
    // bytes accepted and coefficients produced so far.
    task automatic run_frame(input int d, input int pv, input int pr,
                             input int stall_at, input int abort_at, input bit rand_start);
        int          nbytes = 32 * d;
        int          cyc = 0;
        int          stall_left = 0;
        bit          stalled = 0;
        bit          forced = 0;
        bit          prev_hold = 0;
        logic [11:0] prev_coeff = '0;
        logic        prev_last = 1'b0;
        logic        exp_ready;
        bit          finished = 0;
        rx_count = 0; bytes_acc = 0; done_count = 0; done_cyc = -10; last_cyc = -20;
        hold_errs = 0; ready_errs = 0; timed_out = 0; stall_ready_low = 0;
        while (!finished) begin
            @(posedge clk); #1;
            bus.in_valid = (bytes_acc < nbytes) && ($urandom_range(99) < pv);
            bus.in_byte  = bus.in_valid ? tx_bytes[bytes_acc] : 8'($urandom);
            forced = (stall_left > 0);
            if (forced) begin
                bus.out_ready = 1'b0;
                stall_left--;
            end else begin
                bus.out_ready = ($urandom_range(99) < pr);
            end
            start = rand_start && (bytes_acc < nbytes) && ($urandom_range(3) == 0);
            d_sel = 4'($urandom_range(15));
            @(negedge clk);
            cyc++;
            exp_ready = (bytes_acc < nbytes) &&
                        ((8 * bytes_acc - d * (rx_count + int'(bus.out_valid))) <= 12);
            if (bus.in_ready !== exp_ready) ready_errs++;
            if (prev_hold && (bus.out_valid !== 1'b1 || bus.out_coeff !== prev_coeff ||
                              bus.out_last !== prev_last)) hold_errs++;
            if (forced && !bus.in_ready && bytes_acc < nbytes) stall_ready_low = 1;
            prev_hold  = bus.out_valid && !bus.out_ready;
            prev_coeff = bus.out_coeff;
            prev_last  = bus.out_last;
            if (bus.in_valid && bus.in_ready) bytes_acc++;
            if (bus.out_valid && bus.out_ready) begin
                if (rx_count < 256) begin
                    rx_coeff[rx_count] = int'(bus.out_coeff);
                    rx_last[rx_count]  = bus.out_last;
                end
                rx_count++;
                if (bus.out_last) last_cyc = cyc;
            end
            if (stall_at >= 0 && !stalled && rx_count == stall_at) begin
                stalled    = 1;
                stall_left = 6;
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
                finished = 1;
            end
            if (abort_at >= 0 && rx_count >= abort_at) finished = 1;
            if (cyc >= 20000) begin
                timed_out = 1;
                finished  = 1;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        start         = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; d_sel = 4'd0;
        bus.in_valid = 1'b0; bus.in_byte = 8'h00; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_last !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_last: got %b expected 0", bus.out_last); end
        checks++; if (bus.out_coeff !== 12'd0) begin failures++; $display("[TB] FAIL reset_out_coeff: got %0d expected 0", bus.out_coeff); end
        checks++; if ({busy, done, err} !== 3'b000) begin failures++; $display("[TB] FAIL reset_flags: got busy/done/err=%b expected 000", {busy, done, err}); end
        rst_n = 1'b1;
    endtask

    task automatic test_d1_pattern;
        tx_bytes[0] = 8'hA5;
        for (int k = 1; k < 32; k++) tx_bytes[k] = 8'h00;
        build_expected(1);
        start_frame(1);
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL d1_busy: got %b expected 1", busy); end
        run_frame(1, 100, 100, -1, -1, 0);
        checks++; if (timed_out) begin failures++; $display("[TB] FAIL d1_timeout: got rx=%0d expected 256", rx_count); end
        checks++; if (rx_count != 256) begin failures++; $display("[TB] FAIL d1_count: got %0d expected 256", rx_count); end
        for (int i = 0; i < 256; i++) begin
            checks++;
            if (rx_coeff[i] != exp_coeff[i]) begin failures++; $display("[TB] FAIL d1_coeff[%0d]: got %0d expected %0d", i, rx_coeff[i], exp_coeff[i]); end
        end
        for (int i = 0; i < 256; i++) begin
            checks++;
            if (rx_last[i] != (i == 255)) begin failures++; $display("[TB] FAIL d1_last[%0d]: got %0d expected %0d", i, rx_last[i], i == 255); end
        end
        checks++; if (done_cyc != last_cyc + 1) begin failures++; $display("[TB] FAIL d1_done_timing: got cycle %0d expected %0d", done_cyc, last_cyc + 1); end
        checks++; if (ready_errs != 0) begin failures++; $display("[TB] FAIL d1_in_ready: got %0d wrong cycles expected 0", ready_errs); end
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL d1_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_d12_reduce;
        for (int k = 0; k < 384; k++) tx_bytes[k] = 8'($urandom);
        tx_bytes[0] = 8'h00; tx_bytes[1] = 8'h1D; tx_bytes[2] = 8'hD0;
        tx_bytes[3] = 8'hFF; tx_bytes[4] = 8'hFF; tx_bytes[5] = 8'hFF;
        build_expected(12);
        start_frame(12);
        run_frame(12, 70, 70, -1, -1, 0);
        checks++; if (timed_out || rx_count != 256) begin failures++; $display("[TB] FAIL d12_count: got %0d expected 256", rx_count); end
        checks++; if (rx_coeff[0] != 3328) begin failures++; $display("[TB] FAIL d12_c0: got %0d expected 3328", rx_coeff[0]); end
        checks++; if (rx_coeff[1] != 0) begin failures++; $display("[TB] FAIL d12_c1: got %0d expected 0", rx_coeff[1]); end
        checks++; if (rx_coeff[2] != 766) begin failures++; $display("[TB] FAIL d12_c2: got %0d expected 766", rx_coeff[2]); end
        checks++; if (rx_coeff[3] != 766) begin failures++; $display("[TB] FAIL d12_c3: got %0d expected 766", rx_coeff[3]); end
        for (int i = 0; i < 256; i++) begin
            checks++;
            if (rx_coeff[i] != exp_coeff[i]) begin failures++; $display("[TB] FAIL d12_coeff[%0d]: got %0d expected %0d", i, rx_coeff[i], exp_coeff[i]); end
        end
        checks++; if (bytes_acc != 384) begin failures++; $display("[TB] FAIL d12_bytes: got %0d expected 384", bytes_acc); end
        checks++; if (ready_errs != 0 || hold_errs != 0) begin failures++; $display("[TB] FAIL d12_handshake: got ready_errs=%0d hold_errs=%0d expected 0/0", ready_errs, hold_errs); end
    endtask

    task automatic test_d10_stall;
        int sum_rx = 0;
        int sum_exp = 0;
        for (int k = 0; k < 320; k++) tx_bytes[k] = 8'($urandom);
        build_expected(10);
        start_frame(10);
        run_frame(10, 100, 100, 100, -1, 0);
        for (int i = 0; i < 256; i++) begin
            sum_rx  += rx_coeff[i];
            sum_exp += exp_coeff[i];
        end
        checks++; if (timed_out || rx_count != 256) begin failures++; $display("[TB] FAIL d10_count: got %0d expected 256", rx_count); end
        checks++; if (sum_rx != sum_exp) begin failures++; $display("[TB] FAIL d10_sum: got %0d expected %0d", sum_rx, sum_exp); end
        checks++; if (hold_errs != 0) begin failures++; $display("[TB] FAIL d10_hold: got %0d unstable cycles expected 0", hold_errs); end
        checks++; if (stall_ready_low != 1) begin failures++; $display("[TB] FAIL d10_backpressure: got in_ready low=%0d expected 1", stall_ready_low); end
        checks++; if (ready_errs != 0) begin failures++; $display("[TB] FAIL d10_in_ready: got %0d wrong cycles expected 0", ready_errs); end
        for (int i = 0; i < 256; i++) begin
            checks++;
            if (rx_coeff[i] != exp_coeff[i]) begin failures++; $display("[TB] FAIL d10_coeff[%0d]: got %0d expected %0d", i, rx_coeff[i], exp_coeff[i]); end
        end
    endtask

    task automatic test_d4_random;
        for (int k = 0; k < 128; k++) tx_bytes[k] = 8'($urandom);
        build_expected(4);
        start_frame(4);
        run_frame(4, 50, 50, -1, -1, 1);
        checks++; if (timed_out || rx_count != 256) begin failures++; $display("[TB] FAIL d4_count: got %0d expected 256", rx_count); end
        checks++; if (bytes_acc != 128) begin failures++; $display("[TB] FAIL d4_bytes: got %0d expected 128", bytes_acc); end
        for (int i = 0; i < 256; i++) begin
            checks++;
            if (rx_coeff[i] != exp_coeff[i]) begin failures++; $display("[TB] FAIL d4_coeff[%0d]: got %0d expected %0d", i, rx_coeff[i], exp_coeff[i]); end
        end
        checks++; if (ready_errs != 0 || hold_errs != 0) begin failures++; $display("[TB] FAIL d4_handshake: got ready_errs=%0d hold_errs=%0d expected 0/0", ready_errs, hold_errs); end
        checks++; if (done_count != 1 || done_cyc != last_cyc + 1) begin failures++; $display("[TB] FAIL d4_done: got count=%0d cycle=%0d expected 1/%0d", done_count, done_cyc, last_cyc + 1); end
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL d4_idle_ready: got %b expected 0", bus.in_ready); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL d4_done_pulse: got %b expected 0", done); end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_illegal;
        logic [3:0] bad [0:1];
        bad[0] = 4'd0;
        bad[1] = 4'd13;
        for (int n = 0; n < 2; n++) begin
            @(posedge clk); #1;
            start = 1'b1;
            d_sel = bad[n];
            @(posedge clk); #1;
            start = 1'b0;
            checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL illegal_err[%0d]: got %b expected 1", bad[n], err); end
            checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL illegal_idle[%0d]: got busy=%b in_ready=%b expected 0/0", bad[n], busy, bus.in_ready); end
            @(posedge clk); #1;
            checks++; if (err !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL illegal_pulse[%0d]: got err=%b busy=%b expected 0/0", bad[n], err, busy); end
        end
    endtask

    task automatic test_reset_mid_frame;
        for (int k = 0; k < 384; k++) tx_bytes[k] = 8'($urandom);
        build_expected(12);
        start_frame(12);
        run_frame(12, 80, 80, -1, 101, 0);
        checks++; if (rx_count != 101) begin failures++; $display("[TB] FAIL mid_progress: got %0d expected 101", rx_count); end
        checks++; if (rx_coeff[100] != exp_coeff[100]) begin failures++; $display("[TB] FAIL mid_c100: got %0d expected %0d", rx_coeff[100], exp_coeff[100]); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if ({bus.in_ready, bus.out_valid, bus.out_last, busy, done, err} !== 6'b0) begin
            failures++; $display("[TB] FAIL mid_reset_flags: got %b expected 000000", {bus.in_ready, bus.out_valid, bus.out_last, busy, done, err});
        end
        checks++; if (bus.out_coeff !== 12'd0) begin failures++; $display("[TB] FAIL mid_reset_coeff: got %0d expected 0", bus.out_coeff); end
        rst_n = 1'b1;
        for (int k = 0; k < 32; k++) tx_bytes[k] = 8'($urandom);
        build_expected(1);
        start_frame(1);
        run_frame(1, 60, 60, -1, -1, 0);
        checks++; if (timed_out || rx_count != 256) begin failures++; $display("[TB] FAIL post_reset_count: got %0d expected 256", rx_count); end
        for (int i = 0; i < 256; i++) begin
            checks++;
            if (rx_coeff[i] != exp_coeff[i]) begin failures++; $display("[TB] FAIL post_reset_coeff[%0d]: got %0d expected %0d", i, rx_coeff[i], exp_coeff[i]); end
        end
        checks++; if (rx_last[255] != 1'b1 || rx_last[254] != 1'b0) begin failures++; $display("[TB] FAIL post_reset_last: got %0d%0d expected 01", rx_last[254], rx_last[255]); end
    endtask

    // Scenarios run back to back; each leaves the DUT idle for the next.
    initial begin
        test_reset();
        test_d1_pattern();
        test_d12_reduce();
        test_d10_stall();
        test_d4_random();
        test_illegal();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
